// File: rtl/hdmi_pixel_buffer.sv
// Elastic FWFT pixel FIFO feeding the TMDS serialiser; aligns producer frames to the
// serialiser's end-of-frame pulse and resynchronises after underrun or misalignment.
module hdmi_pixel_buffer #(
    parameter int          LGDEPTH   = 5,
    parameter logic [23:0] BLANK_RGB = 24'h000000
) (
    input  logic               i_pixclk,
    input  logic               i_reset,
    input  logic [23:0]        i_data,
    input  logic               i_sof,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_rd,
    input  logic               i_newframe,
    input  logic               i_clr_err,
    output logic [7:0]         o_red,
    output logic [7:0]         o_grn,
    output logic [7:0]         o_blu,
    output logic [LGDEPTH:0]   o_fill,
    output logic               o_underrun,
    output logic               o_misalign,
    output logic               o_locked
);

    localparam int                 DEPTH     = 2 ** LGDEPTH;
    localparam logic [LGDEPTH:0]   FILL_FULL = DEPTH;
    localparam logic [LGDEPTH:0]   FILL_ZERO = 0;
    localparam logic [LGDEPTH:0]   FILL_ONE  = 1;
    localparam logic [LGDEPTH-1:0] PTR_ZERO  = 0;
    localparam logic [LGDEPTH-1:0] PTR_ONE   = 1;

    typedef enum logic [1:0] {
        ST_ALIGN  = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    logic [24:0]        mem_r [DEPTH];
    logic [LGDEPTH-1:0] wr_ptr_r;
    logic [LGDEPTH-1:0] rd_ptr_r;
    logic [LGDEPTH:0]   fill_r;
    state_t             state_r;
    logic               expect_sof_r;
    logic               underrun_r;
    logic               misalign_r;

    logic               head_valid_s;
    logic               head_sof_s;
    logic [23:0]        head_data_s;
    logic               push_s;
    logic               pop_s;
    logic               misalign_set_s;
    logic               underrun_set_s;
    logic [23:0]        rgb_s;

    assign o_ready      = (fill_r != FILL_FULL);
    assign push_s       = i_valid && o_ready;
    assign head_valid_s = (fill_r != FILL_ZERO);
    assign head_sof_s   = mem_r[rd_ptr_r][24];
    assign head_data_s  = mem_r[rd_ptr_r][23:0];

    // Storage array; contents need no reset because fill gates every read.
    always_ff @(posedge i_pixclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {i_sof, i_data};
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the fill unchanged.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            fill_r   <= FILL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + FILL_ONE;
                2'b01:   fill_r <= fill_r - FILL_ONE;
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Pop decision and error events, all decided in the cycle the serialiser strobes.
    always_comb begin
        pop_s          = 1'b0;
        misalign_set_s = 1'b0;
        underrun_set_s = 1'b0;
        case (state_r)
            ST_ALIGN: begin
                pop_s = head_valid_s && !head_sof_s;
            end
            ST_ARMED: begin
                pop_s = 1'b0;
            end
            ST_STREAM: begin
                if (i_rd) begin
                    pop_s          = head_valid_s;
                    misalign_set_s = head_valid_s && (expect_sof_r ^ head_sof_s);
                    underrun_set_s = !head_valid_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Alignment FSM with expected-SOF tracking and sticky error flags (set beats clear).
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= ST_ALIGN;
            expect_sof_r <= 1'b0;
            underrun_r   <= 1'b0;
            misalign_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_ALIGN: begin
                    if (head_valid_s && head_sof_s) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_ALIGN;
                    end
                end
                ST_ARMED: begin
                    if (i_newframe) begin
                        state_r      <= ST_STREAM;
                        expect_sof_r <= 1'b1;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_STREAM: begin
                    if (misalign_set_s || underrun_set_s) begin
                        state_r <= ST_ALIGN;
                    end else begin
                        state_r <= ST_STREAM;
                    end
                    // The pixel check above already used the old value, so a
                    // coincident newframe only affects the next pixel.
                    if (i_newframe) begin
                        expect_sof_r <= 1'b1;
                    end else if (pop_s) begin
                        expect_sof_r <= 1'b0;
                    end else begin
                        expect_sof_r <= expect_sof_r;
                    end
                end
                default: begin
                    state_r      <= ST_ALIGN;
                    expect_sof_r <= 1'b0;
                end
            endcase

            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (i_clr_err) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end

            if (misalign_set_s) begin
                misalign_r <= 1'b1;
            end else if (i_clr_err) begin
                misalign_r <= 1'b0;
            end else begin
                misalign_r <= misalign_r;
            end
        end
    end

    // Colour presented to the serialiser in the same cycle as its read strobe.
    always_comb begin
        if ((state_r == ST_STREAM) && head_valid_s && !misalign_set_s) begin
            rgb_s = head_data_s;
        end else begin
            rgb_s = BLANK_RGB;
        end
    end

    assign o_red      = rgb_s[23:16];
    assign o_grn      = rgb_s[15:8];
    assign o_blu      = rgb_s[7:0];
    assign o_fill     = fill_r;
    assign o_underrun = underrun_r;
    assign o_misalign = misalign_r;
    assign o_locked   = (state_r == ST_STREAM);

endmodule

// File: tb/tb_hdmi_pixel_buffer.sv
// Bench for hdmi_pixel_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the buffer's frame-alignment rules.
module tb_hdmi_pixel_buffer;

    localparam int          LGDEPTH = 5;
    localparam int          DEPTH   = 32;
    localparam logic [23:0] BLANK   = 24'h0A0B0C;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data;
    logic        sof, valid, rd, newframe, clr_err;
    logic        ready, underrun, misalign, locked;
    logic [7:0]  red, grn, blu;
    logic [LGDEPTH:0] fill;

    int errors = 0;
    int checks = 0;

    hdmi_pixel_buffer #(.LGDEPTH(LGDEPTH), .BLANK_RGB(BLANK)) dut (
        .i_pixclk(clk), .i_reset(rst), .i_data(data), .i_sof(sof), .i_valid(valid),
        .o_ready(ready), .i_rd(rd), .i_newframe(newframe), .i_clr_err(clr_err),
        .o_red(red), .o_grn(grn), .o_blu(blu), .o_fill(fill),
        .o_underrun(underrun), .o_misalign(misalign), .o_locked(locked)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a queue of {sof,data}, plus mode and flags.
    typedef enum int {M_ALIGN, M_ARMED, M_STREAM} mode_t;
    logic [24:0] q[$];
    mode_t       mode;
    bit          m_exp, m_und, m_mis;

    function automatic void model_reset();
        q.delete();
        mode  = M_ALIGN;
        m_exp = 1'b0;
        m_und = 1'b0;
        m_mis = 1'b0;
    endfunction

    function automatic logic [23:0] exp_rgb();
        if (mode == M_STREAM && q.size() > 0 && !(rd && (m_exp != q[0][24])))
            return q[0][23:0];
        return BLANK;
    endfunction

    function automatic void model_edge();
        bit    hv, hs, push, pop, mis, und, nexp;
        mode_t nmode;
        hv    = (q.size() > 0);
        hs    = hv ? q[0][24] : 1'b0;
        push  = valid && (q.size() < DEPTH);
        pop   = 1'b0;
        mis   = 1'b0;
        und   = 1'b0;
        nexp  = m_exp;
        nmode = mode;
        case (mode)
            M_ALIGN: begin
                if (hv && !hs) pop = 1'b1;
                else if (hv) nmode = M_ARMED;
            end
            M_ARMED: begin
                if (newframe) begin nmode = M_STREAM; nexp = 1'b1; end
            end
            M_STREAM: begin
                if (rd && hv) begin
                    pop = 1'b1;
                    if (m_exp != hs) begin mis = 1'b1; nmode = M_ALIGN; end
                    else nexp = 1'b0;
                end else if (rd) begin
                    und = 1'b1;
                    nmode = M_ALIGN;
                end
                if (newframe) nexp = 1'b1;
            end
            default: nmode = M_ALIGN;
        endcase
        if (mis) m_mis = 1'b1; else if (clr_err) m_mis = 1'b0;
        if (und) m_und = 1'b1; else if (clr_err) m_und = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) q.push_back({sof, data});
        mode  = nmode;
        m_exp = nexp;
    endfunction

    task automatic set_in(input logic v, input logic [23:0] d, input logic s,
                          input logic r, input logic nf, input logic c);
        valid = v; data = d; sof = s; rd = r; newframe = nf; clr_err = c;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        valid = 1'b0; data = 24'h000000; sof = 1'b0; rd = 1'b0;
        newframe = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (fill !== 6'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if ({locked, underrun, misalign} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {locked, underrun, misalign}); end
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL reset_rgb got=%h exp=%h", {red, grn, blu}, BLANK); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_stream();
        logic [23:0] px [4];
        px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, px[i], (i == 0), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(); tick();
        checks++; if (fill !== 6'd4) begin errors++; $display("FAIL basic_fill4 got=%0d exp=4", fill); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_armed_lock got=%b exp=0", locked); end
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); idle();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked got=%b exp=1", locked); end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if ({red, grn, blu} !== px[i]) begin
                errors++; $display("FAIL basic_rgb%0d got=%h exp=%h", i, {red, grn, blu}, px[i]); end
            checks++; if (fill !== 6'(4 - i)) begin
                errors++; $display("FAIL basic_fill%0d got=%0d exp=%0d", i, fill, 4 - i); end
            tick();
        end
        idle();
        checks++; if ({fill, underrun, misalign} !== 8'h00) begin
            errors++; $display("FAIL basic_end got=%0d/%b%b exp=0/00", fill, underrun, misalign); end
    endtask

    task automatic test_underrun();
        set_in(1'b1, 24'h5A5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL und_rgb got=%h exp=%h", {red, grn, blu}, BLANK); end
        tick(); idle();
        checks++; if ({underrun, locked, fill} !== {1'b1, 1'b0, 6'd1}) begin
            errors++; $display("FAIL und_set got=%b%b/%0d exp=10/1", underrun, locked, fill); end
        set_in(1'b1, 24'h343434, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        checks++; if (fill !== 6'd1) begin errors++; $display("FAIL und_discard1 got=%0d exp=1", fill); end
        set_in(1'b1, 24'h565656, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        idle(); tick(); tick();
        checks++; if ({fill, locked} !== {6'd1, 1'b0}) begin
            errors++; $display("FAIL und_armed got=%0d/%b exp=1/0", fill, locked); end
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL und_armed_rgb got=%h exp=%h", {red, grn, blu}, BLANK); end
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick(); idle();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_clear got=%b exp=0", underrun); end
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== 24'h565656) begin
            errors++; $display("FAIL und_resync got=%h exp=565656", {red, grn, blu}); end
        tick(); idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 24'h200000 + 24'(i), (i == 0), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        checks++; if ({fill, ready} !== {6'd32, 1'b0}) begin
            errors++; $display("FAIL full_fill got=%0d/%b exp=32/0", fill, ready); end
        set_in(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        checks++; if (fill !== 6'd32) begin errors++; $display("FAIL full_reject got=%0d exp=32", fill); end
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== 24'h200000) begin
            errors++; $display("FAIL full_pop0 got=%h exp=200000", {red, grn, blu}); end
        tick();
        set_in(1'b1, 24'h300000, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({fill, ready} !== {6'd31, 1'b1}) begin
            errors++; $display("FAIL full_ready got=%0d/%b exp=31/1", fill, ready); end
        checks++; if ({red, grn, blu} !== 24'h200001) begin
            errors++; $display("FAIL full_pop1 got=%h exp=200001", {red, grn, blu}); end
        tick(); idle();
        checks++; if (fill !== 6'd31) begin errors++; $display("FAIL full_pushpop got=%0d exp=31", fill); end
    endtask

    task automatic test_misalign();
        logic [23:0] px [5];
        px = '{24'h010101, 24'h020202, 24'h030303, 24'h040404, 24'h050505};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, px[i], (i == 0 || i == 3), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(); tick(); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if ({red, grn, blu} !== px[i]) begin
                errors++; $display("FAIL mis_rgb%0d got=%h exp=%h", i, {red, grn, blu}, px[i]); end
            tick();
        end
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL mis_blank got=%h exp=%h", {red, grn, blu}, BLANK); end
        tick(); idle();
        checks++; if ({misalign, locked} !== 2'b10) begin
            errors++; $display("FAIL mis_set got=%b%b exp=10", misalign, locked); end
        set_in(1'b1, 24'h060606, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 24'h070707, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        idle(); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== 24'h060606) begin
            errors++; $display("FAIL mis_f got=%h exp=060606", {red, grn, blu}); end
        tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL mis_g_blank got=%h exp=%h", {red, grn, blu}, BLANK); end
        tick(); idle();
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_setwins got=%b exp=1", misalign); end
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick(); idle();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", misalign); end
    endtask

    task automatic test_newframe_coincide();
        logic [23:0] px [4];
        px = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, px[i], (i == 0 || i == 2), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(); tick(); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if ({red, grn, blu} !== 24'h222222) begin
            errors++; $display("FAIL nf_coincide got=%h exp=222222", {red, grn, blu}); end
        tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== 24'h333333) begin
            errors++; $display("FAIL nf_sof_ok got=%h exp=333333", {red, grn, blu}); end
        tick(); idle();
        checks++; if ({misalign, locked} !== 2'b01) begin
            errors++; $display("FAIL nf_no_err got=%b%b exp=01", misalign, locked); end
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL nf_nosof_blank got=%h exp=%h", {red, grn, blu}, BLANK); end
        tick(); idle();
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL nf_nosof_flag got=%b exp=1", misalign); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_in(1'b1, 24'h600000 + 24'(i), (i == 0), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        end
        idle();
        checks++; if ({fill, locked} !== {6'd10, 1'b1}) begin
            errors++; $display("FAIL mid_pre got=%0d/%b exp=10/1", fill, locked); end
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if ({fill, ready, locked, underrun, misalign} !== {6'd0, 1'b1, 3'b000}) begin
            errors++; $display("FAIL mid_async got=%0d/%b%b%b%b exp=0/1000", fill, ready, locked, underrun, misalign); end
        checks++; if ({red, grn, blu} !== BLANK) begin
            errors++; $display("FAIL mid_rgb got=%h exp=%h", {red, grn, blu}, BLANK); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, 24'h700000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); idle();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_nosof got=%b exp=0", locked); end
        set_in(1'b1, 24'h710000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        idle(); tick();
        set_in(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); idle();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_relock got=%b exp=1", locked); end
    endtask

    task automatic test_random();
        logic [33:0] got, exp;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            set_in(($urandom_range(0, 9) < 7), 24'($urandom), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0),
                   ($urandom_range(0, 29) == 0));
            got = {red, grn, blu, fill, ready, locked, underrun, misalign};
            exp = {exp_rgb(), 6'(q.size()), (q.size() != DEPTH), (mode == M_STREAM), m_und, m_mis};
            checks++; if (got !== exp) begin
                errors++; $display("FAIL rand_cycle%0d got=%h exp=%h", n, got, exp); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_underrun();
        test_full();
        test_misalign();
        test_newframe_coincide();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
